// File: rtl/d_flip_flop_pkg.sv
// ============================================================================
// Module  : d_flip_flop_pkg
// Brief   : Default configuration shared by the d_flip_flop register slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package d_flip_flop_pkg;

    localparam int c_DEFAULT_WIDTH  = 1;
    localparam int c_DEFAULT_STAGES = 1;

endpackage

`default_nettype wire

// File: rtl/d_flip_flop_stage.sv
// ============================================================================
// Module  : d_flip_flop_stage
// Brief   : Single WIDTH-bit register with synchronous active-high reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module d_flip_flop_stage
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = c_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= D;
        end
    end

    assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/d_flip_flop.sv
// ============================================================================
// Module  : d_flip_flop
// Brief   : Parameterisable D register / delay line of STAGES cascaded stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = c_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               STAGES      = c_DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "d_flip_flop: WIDTH must be >= 1");
        end
        if (STAGES < 1) begin : g_bad_stages
            $fatal(1, "d_flip_flop: STAGES must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] w_stage_q [STAGES];

    // All stages share rst, so the whole pipeline clears on one edge.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] w_d;
            if (gi == 0) begin : g_first
                assign w_d = D;
            end else begin : g_chain
                assign w_d = w_stage_q[gi-1];
            end

            d_flip_flop_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .D   (w_d),
                .Q   (w_stage_q[gi])
            );
        end
    endgenerate

    assign Q = w_stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_d_flip_flop.sv
// ============================================================================
// Module  : tb_d_flip_flop
// Brief   : Self-checking bench for the default and a wide/deep d_flip_flop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_flip_flop;

    localparam logic [7:0] c_RV8 = 8'hA5;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int n_checks;
    int n_errors;

    // History of what was sampled on each rising edge, newest first.
    logic       h_rst [$];
    logic       h_d1  [$];
    logic [7:0] h_d8  [$];

    d_flip_flop u_dut1 (
        .clk (clk),
        .rst (rst),
        .D   (d1),
        .Q   (q1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (c_RV8),
        .STAGES      (3)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .D   (d8),
        .Q   (q8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Q after an edge is the D sampled STAGES-1 edges earlier, unless any
    // of the last STAGES edges was a reset edge.
    function automatic logic exp_q1();
        if (h_rst[0]) return 1'b0;
        return h_d1[0];
    endfunction

    function automatic logic [7:0] exp_q8();
        for (int k = 0; k < 3; k++) begin
            if (k >= h_rst.size()) return c_RV8;
            if (h_rst[k]) return c_RV8;
        end
        return h_d8[2];
    endfunction

    task automatic record_edge();
        h_rst.push_front(rst);
        h_d1.push_front(d1);
        h_d8.push_front(d8);
        if (h_rst.size() > 3) begin
            void'(h_rst.pop_back());
            void'(h_d1.pop_back());
            void'(h_d8.pop_back());
        end
    endtask

    task automatic check1(input string tag, input logic expected);
        n_checks++;
        assert (q1 === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, q1, expected);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] expected);
        n_checks++;
        assert (q8 === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, q8, expected);
        end
    endtask

    // Drive inputs away from the edge, take one edge, check 1 time unit after.
    task automatic cycle(input string tag, input logic r, input logic a, input logic [7:0] b);
        rst = r;
        d1  = a;
        d8  = b;
        @(posedge clk);
        record_edge();
        #1;
        check1({tag, "_q1"}, exp_q1());
        check8({tag, "_q8"}, exp_q8());
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        d1  = 1'b0;
        d8  = 8'h00;

        // Reset, then reset priority over D=1.
        cycle("reset_d0", 1'b1, 1'b0, 8'h00);
        check1("reset_d0_const", 1'b0);
        check8("reset_rv_const", c_RV8);
        cycle("reset_d1", 1'b1, 1'b1, 8'hFF);
        check1("reset_prio_const", 1'b0);

        // Basic transfer and wide/deep fill.
        cycle("xfer0", 1'b0, 1'b0, 8'h01);
        check1("xfer0_const", 1'b0);
        cycle("xfer1", 1'b0, 1'b1, 8'h02);
        check1("xfer1_const", 1'b1);
        cycle("xfer2", 1'b0, 1'b0, 8'h03);
        check8("fill_first_const", 8'h01);
        cycle("xfer3", 1'b0, 1'b1, 8'h04);
        check8("fill_second_const", 8'h02);
        cycle("xfer4", 1'b0, 1'b1, 8'h05);
        check8("fill_third_const", 8'h03);

        // Hold: D toggles between edges, Q must not move until the edge.
        d1 = 1'b0;
        #1 check1("hold_mid_a", 1'b1);
        d1 = 1'b1;
        #1 d1 = 1'b0;
        #1 check1("hold_mid_b", 1'b1);
        cycle("hold_edge", 1'b0, 1'b1, 8'h06);

        // Reset during fill and mid-stream with Q=1, D=1.
        cycle("pre_rst", 1'b0, 1'b1, 8'h07);
        cycle("mid_rst", 1'b1, 1'b1, 8'h08);
        check1("mid_rst_const", 1'b0);
        check8("mid_rst8_const", c_RV8);
        cycle("post_rst0", 1'b0, 1'b1, 8'h09);
        check1("post_rst0_const", 1'b1);
        check8("post_rst0_8_const", c_RV8);
        cycle("post_rst1", 1'b0, 1'b0, 8'h0A);
        check8("post_rst1_8_const", c_RV8);
        cycle("post_rst2", 1'b0, 1'b0, 8'h0B);
        check8("post_rst2_8_const", 8'h09);

        // Randomized traffic against the history model.
        for (int n = 0; n < 300; n++) begin
            cycle("rand", ($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
